axis_mux_2to1: RTL and testbench
================================

Name: axis_mux_2to1

Overview:
- Two-input AXI-Stream style packet multiplexer. Forwards one of two slave streams (s_*_1, s_*_2) to a single master stream (m_*), chosen by `sel`.
- Switching between sources happens only at packet boundaries (`last`), so packets are never interleaved.
- The master side is registered through a 2-entry skid buffer.
- Sits between two packet producers and one downstream consumer in the streaming datapath.

Parameters:
- DATA_WIDTH, 8, width of s_data_1, s_data_2 and m_data.

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- sel  in  1  source select: 0 = slave 1, 1 = slave 2; only honoured at packet boundaries.
- s_data_1  in  DATA_WIDTH  slave 1 data.
- s_valid_1  in  1  slave 1 valid.
- s_ready_1  out  1  slave 1 ready.
- s_last_1  in  1  slave 1 end-of-packet.
- s_data_2  in  DATA_WIDTH  slave 2 data.
- s_valid_2  in  1  slave 2 valid.
- s_ready_2  out  1  slave 2 ready.
- s_last_2  in  1  slave 2 end-of-packet.
- m_data  out  DATA_WIDTH  master data.
- m_valid  out  1  master valid.
- m_ready  in  1  master ready.
- m_last  out  1  master end-of-packet.

Behaviour:
- Reset (reset==0 at a posedge):
  - m_valid=0, m_data=0, m_last=0.
  - Skid buffer emptied, arbiter set to IDLE.
  - s_ready_1=s_ready_2=0 while reset is low.
  - Reset mid-packet discards buffered beats and the lock, with no error indication.
- Handshakes:
  - A slave beat transfers when s_valid_x && s_ready_x at a posedge.
  - A master beat transfers when m_valid && m_ready.
  - Once m_valid is asserted, m_data, m_valid and m_last stay stable until accepted.
- Grant / arbiter, two states:
  - IDLE: effective grant g = sel (combinational).
  - LOCK: g = the registered lock_src.
  - IDLE->LOCK: accepted beat from source g with last=0; lock_src <= g.
  - LOCK->IDLE: accepted beat from lock_src with last=1.
  - A single-beat packet (last=1 accepted in IDLE) stays in IDLE.
  - sel changes while in LOCK are ignored; the new sel takes effect on the first beat after the packet's last beat.
- Readiness:
  - s_ready_g = ~skid_full.
  - The non-granted s_ready is always 0.
  - s_ready is registered (no combinational path from m_ready).
  - The non-granted source's valid/data/last are ignored completely.
- Datapath (2-entry skid buffer):
  - Latency: a beat accepted at edge N is presented on m_* after edge N.
  - Full throughput: 1 beat per clock when m_ready is held at 1.
  - Order is preserved; data, last and source pairing stay intact.
- Boundary conditions:
  - m_ready=0 with the skid buffer full: s_ready drops the next cycle and no beat is lost.
  - Simultaneous slave accept and master accept on the same edge: occupancy is unchanged.
  - m_last is passed through bit-exact with its data beat.

Decomposition:
- Shared package: DATA_WIDTH default; arbiter state enum {IDLE, LOCK}; select encodings SEL_S1=0, SEL_S2=1.
- One natural sub-module: axis_skid_buffer (2-entry register slice, DATA_WIDTH+1 bits wide, carrying data and last).
- Arbiter and input mux stay in the top level.

Test Plan:
- Reset, m_ready=1, sel=0, s_valid_1=1, data 0x11, 0x22, 0x33 with last on 0x33:
  - During reset, m_valid=0 and both s_ready=0.
  - After reset, m_data shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance.
  - m_last=1 only with 0x33.
- Packet lock:
  - Stimulus: slave 1 sends a 4-beat packet 0xA0..0xA3; sel toggles to 1 after beat 2; slave 2 is valid with 0xB0 (last=1).
  - Required: all 4 0xA* beats come out first, then 0xB0.
  - s_ready_2 stays 0 until 0xA3 (last) is accepted.
- Backpressure: stream 0x01..0x08 continuously, hold m_ready=0 for 5 cycles mid-stream.
  - s_ready_1 deasserts within 2 accepted beats.
  - No loss or duplication: output is exactly 0x01..0x08.
- Single-beat packets with sel toggling every 2 cycles:
  - Output alternates sources per packet, consistent with sel at each boundary.
- Reset mid-packet:
  - Stimulus: assert reset after 2 of 4 beats.
  - Required: m_valid=0 the next cycle; arbiter back in IDLE and follows sel on the first new beat.
- Non-granted noise:
  - Stimulus: sel=0 with random s_data_2/s_valid_2/s_last_2.
  - Required: s_ready_2=0 throughout; m_data is never taken from slave 2.

Source files
------------

// File: rtl/axis_mux_2to1_pkg.sv
// Shared types and constants for the two-input AXI-Stream packet multiplexer.
package axis_mux_2to1_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam logic SEL_S1 = 1'b0;
    localparam logic SEL_S2 = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice; the head entry drives the output directly so the
// output is stable while valid, and the ready flag comes straight from a register.
module axis_skid_buffer
    import axis_mux_2to1_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 2'd0;
            head  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Leave a stale head when draining the last entry; it is masked by out_valid.
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= in_data;
                    end else begin
                        head <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_mux_2to1.sv
// Two-input AXI-Stream packet multiplexer; the source only switches after a
// beat with last set, so packets from the two slaves are never interleaved.
module axis_mux_2to1
    import axis_mux_2to1_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s_data_1,
    input  logic                  s_valid_1,
    output logic                  s_ready_1,
    input  logic                  s_last_1,
    input  logic [DATA_WIDTH-1:0] s_data_2,
    input  logic                  s_valid_2,
    output logic                  s_ready_2,
    input  logic                  s_last_2,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  lock_src;
    logic                  lock_src_next;
    logic                  grant;
    logic                  skid_ready;
    logic                  in_valid;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  accept;

    assign grant     = (state == LOCK) ? lock_src : sel;
    assign s_ready_1 = reset & skid_ready & (grant == SEL_S1);
    assign s_ready_2 = reset & skid_ready & (grant == SEL_S2);
    assign in_valid  = (grant == SEL_S2) ? s_valid_2 : s_valid_1;
    assign in_last   = (grant == SEL_S2) ? s_last_2  : s_last_1;
    assign in_data   = (grant == SEL_S2) ? s_data_2  : s_data_1;
    assign accept    = in_valid & reset & skid_ready;

    always_comb begin
        state_next    = state;
        lock_src_next = lock_src;
        case (state)
            IDLE: begin
                // A single-beat packet never leaves IDLE.
                if (accept && !in_last) begin
                    state_next    = LOCK;
                    lock_src_next = grant;
                end
            end
            LOCK: begin
                if (accept && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            lock_src <= SEL_S1;
        end else begin
            state    <= state_next;
            lock_src <= lock_src_next;
        end
    end

    axis_skid_buffer #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({in_last, in_data}),
        .in_valid (in_valid),
        .in_ready (skid_ready),
        .out_data ({m_last, m_data}),
        .out_valid(m_valid),
        .out_ready(m_ready)
    );

endmodule

// File: tb/tb_axis_mux_2to1.sv
// Self-checking bench: a queue-based model of the packet mux predicts readiness
// and output beats every cycle; each scenario also checks its output sequence.
module tb_axis_mux_2to1;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic [7:0] s_data_1, s_data_2, m_data;
    logic       s_valid_1, s_ready_1, s_last_1;
    logic       s_valid_2, s_ready_2, s_last_2;
    logic       m_valid, m_ready, m_last;

    int checks = 0;
    int failures = 0;

    logic [8:0] src1_q[$], src2_q[$], mdl_q[$], out_log[$], exp_q[$];
    logic       sel_q[$], mr_q[$];
    bit         mdl_lock;
    logic       mdl_src;
    bit         gaps, noise2, rand_mr;
    int         stall_acc, max_stall_acc;

    always #5 clk = ~clk;

    axis_mux_2to1 #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .s_data_1(s_data_1), .s_valid_1(s_valid_1), .s_ready_1(s_ready_1), .s_last_1(s_last_1),
        .s_data_2(s_data_2), .s_valid_2(s_valid_2), .s_ready_2(s_ready_2), .s_last_2(s_last_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    // Drives n cycles from the source queues and compares the DUT against the model.
    task automatic run(input int n);
        logic g, r1, r2, mv, acc, gl;
        logic [8:0] beat;
        for (int c = 0; c < n; c++) begin
            if (sel_q.size() > 0) sel = sel_q.pop_front();
            if (mr_q.size() > 0) m_ready = mr_q.pop_front();
            else if (rand_mr)    m_ready = 1'($urandom_range(0, 1));
            else                 m_ready = 1'b1;
            s_valid_1 = (src1_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
            {s_last_1, s_data_1} = (src1_q.size() > 0) ? src1_q[0] : 9'h0;
            if (noise2) begin
                s_valid_2 = 1'($urandom_range(0, 1));
                {s_last_2, s_data_2} = 9'($urandom);
            end else begin
                s_valid_2 = (src2_q.size() > 0);
                {s_last_2, s_data_2} = (src2_q.size() > 0) ? src2_q[0] : 9'h0;
            end
            @(negedge clk);
            g    = mdl_lock ? mdl_src : sel;
            r1   = reset && (g == 1'b0) && (mdl_q.size() < 2);
            r2   = reset && (g == 1'b1) && (mdl_q.size() < 2);
            mv   = (mdl_q.size() > 0);
            beat = mv ? mdl_q[0] : 9'h0;
            checks++;
            if ({s_ready_1, s_ready_2, m_valid, (m_valid ? {m_last, m_data} : 9'h0)} !== {r1, r2, mv, beat}) begin
                failures++;
                $display("FAIL cycle_model t=%0t got rdy1=%b rdy2=%b mvalid=%b last_data=%h required rdy1=%b rdy2=%b mvalid=%b last_data=%h",
                         $time, s_ready_1, s_ready_2, m_valid, {m_last, m_data}, r1, r2, mv, beat);
            end
            if (m_valid && m_ready && reset) out_log.push_back({m_last, m_data});
            acc = 1'b0;
            if (!reset) begin
                mdl_q.delete();
                mdl_lock = 0;
            end else begin
                acc = g ? (s_valid_2 && r2) : (s_valid_1 && r1);
                gl  = g ? s_last_2 : s_last_1;
                if (mv && m_ready) void'(mdl_q.pop_front());
                if (acc) begin
                    mdl_q.push_back(g ? {s_last_2, s_data_2} : {s_last_1, s_data_1});
                    if (g) begin
                        if (!noise2) void'(src2_q.pop_front());
                    end else begin
                        void'(src1_q.pop_front());
                    end
                    if (!mdl_lock && !gl) begin
                        mdl_lock = 1;
                        mdl_src  = g;
                    end else if (mdl_lock && gl) begin
                        mdl_lock = 0;
                    end
                end
            end
            if (m_ready) stall_acc = 0;
            else if (acc) stall_acc++;
            if (stall_acc > max_stall_acc) max_stall_acc = stall_acc;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; sel = 1'b0; m_ready = 1'b1;
        s_valid_1 = 1'b1; s_data_1 = 8'h5A; s_last_1 = 1'b0;
        s_valid_2 = 1'b1; s_data_2 = 8'hA5; s_last_2 = 1'b0;
        mdl_lock = 0; mdl_src = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({s_ready_1, s_ready_2, m_valid, m_last, m_data} !== 12'h000) begin
                failures++;
                $display("FAIL reset_state got rdy1=%b rdy2=%b mvalid=%b mlast=%b mdata=%h required all zero",
                         s_ready_1, s_ready_2, m_valid, m_last, m_data);
            end
            @(posedge clk);
            #1;
        end
        s_valid_1 = 1'b0; s_valid_2 = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        out_log.delete();
        src1_q = '{9'h011, 9'h022, 9'h133};
        sel_q  = '{1'b0};
        run(6);
        exp_q = '{9'h011, 9'h022, 9'h133};
        checks++;
        if (out_log.size() != exp_q.size()) begin
            failures++;
            $display("FAIL basic_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got %h required %h", i, out_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        out_log.delete();
        src1_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
        src2_q = '{9'h1B0};
        sel_q  = '{1'b0, 1'b0, 1'b1};
        run(8);
        exp_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3, 9'h1B0};
        checks++;
        if (out_log.size() != exp_q.size()) begin
            failures++;
            $display("FAIL lock_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lock_beat%0d got %h required %h", i, out_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_log.delete();
        stall_acc = 0; max_stall_acc = 0;
        sel_q = '{1'b0};
        for (int i = 1; i <= 8; i++) src1_q.push_back({(i == 8), 8'(i)});
        mr_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run(18);
        checks++;
        if (max_stall_acc > 2) begin
            failures++;
            $display("FAIL bp_stall_accepts got %0d required <=2", max_stall_acc);
        end
        checks++;
        if (out_log.size() != 8) begin
            failures++;
            $display("FAIL bp_count got %0d required 8", out_log.size());
        end
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] !== {(i == 7), 8'(i + 1)}) begin
                failures++;
                $display("FAIL bp_beat%0d got %h required %h", i, out_log[i], {(i == 7), 8'(i + 1)});
            end
        end
    endtask

    task automatic test_single_beat();
        out_log.delete();
        src1_q = '{9'h110, 9'h111, 9'h112, 9'h113};
        src2_q = '{9'h120, 9'h121, 9'h122, 9'h123};
        sel_q  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run(10);
        exp_q = '{9'h110, 9'h111, 9'h120, 9'h121, 9'h112, 9'h113, 9'h122, 9'h123};
        checks++;
        if (out_log.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_beat%0d got %h required %h", i, out_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        src1_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
        sel_q  = '{1'b0};
        run(2);
        reset = 1'b0;
        mr_q  = '{1'b0};
        run(1);
        reset = 1'b1;
        src1_q = '{9'h0D0};
        src2_q = '{9'h1C5};
        sel_q  = '{1'b1};
        out_log.delete();
        run(4);
        checks++;
        if (out_log.size() != 1 || out_log[0] !== 9'h1C5) begin
            failures++;
            $display("FAIL rst_mid_follow_sel got count=%0d first=%h required count=1 first=1c5",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 9'h0);
        end
        src1_q.delete();
        sel_q = '{1'b0};
        run(2);
    endtask

    task automatic test_noise();
        out_log.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) src1_q.push_back({(i == 5) ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom)});
        exp_q = src1_q;
        gaps = 1; noise2 = 1; rand_mr = 1;
        sel_q = '{1'b0};
        run(60);
        gaps = 0; rand_mr = 0;
        run(4);
        noise2 = 0;
        checks++;
        if (out_log.size() != exp_q.size()) begin
            failures++;
            $display("FAIL noise_count got %0d required %0d", out_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
            checks++;
            if (out_log[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL noise_beat%0d got %h required %h", i, out_log[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        gaps = 0; noise2 = 0; rand_mr = 0;
        stall_acc = 0; max_stall_acc = 0;
        test_reset();
        test_basic();
        test_packet_lock();
        test_backpressure();
        test_single_beat();
        test_reset_mid_packet();
        test_noise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
